// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: word/register widths, the EX/MEM sequencer state,
// and the packed payload held by the EX/MEM latch.
package cpu_types_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned STALLCNT_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } exmem_state_t;

    // Everything the EX/MEM latch carries from execute to memory.
    typedef struct packed {
        word_t    npc;
        word_t    aluout;
        word_t    rdat2;
        regbits_t wsel;
        logic     regw;
        logic     dren;
        logic     dwen;
        logic     jump;
        logic     halt;
    } exmem_latch_t;

endpackage

// File: rtl/exmem_if.sv
// Bundle of EX/MEM signals for integration.
// Modports:
//   exmem - the EX/MEM latch and dcache sequencer itself
//   memwb - the MEM/WB latch reading the latched values and load data
//   hazard - the hazard/forwarding unit (drives enable/flush, reads status)
interface exmem_if;
    import cpu_types_pkg::*;

    logic     enable, flush;
    word_t    npc_i, aluout_i, rdat2_i;
    regbits_t wsel_i;
    logic     RegW_i, DRen_i, DWen_i, jump_i, halt_i;
    logic     dhit;
    word_t    dmemload;
    word_t    npc_o, aluout_o, rdat2_o;
    regbits_t wsel_o;
    logic     RegW_o, DRen_o, DWen_o, jump_o, halt_o;
    word_t    dload_o;
    logic     dmemREN, dmemWEN;
    word_t    dmemaddr, dmemstore;
    logic     mem_stall, halted;

    modport exmem (
        input  enable, flush, npc_i, aluout_i, rdat2_i, wsel_i,
               RegW_i, DRen_i, DWen_i, jump_i, halt_i, dhit, dmemload,
        output npc_o, aluout_o, rdat2_o, wsel_o, RegW_o, DRen_o, DWen_o,
               jump_o, halt_o, dload_o, dmemREN, dmemWEN, dmemaddr,
               dmemstore, mem_stall, halted
    );

    modport memwb (
        input npc_o, aluout_o, rdat2_o, wsel_o, RegW_o, DRen_o, DWen_o,
              jump_o, halt_o, dload_o
    );

    modport hazard (
        output enable, flush,
        input  mem_stall, halted, wsel_o, RegW_o, DRen_o
    );

endinterface

// File: rtl/exmem.sv
// EX/MEM pipeline latch with dcache request sequencer.
// Latches execute results when permitted, issues a single load/store to the
// dcache and stalls upstream until dhit, and freezes permanently on HALT.
// Ports:
//   CLK, nRST            clock, async active-low reset
//   enable, flush        hazard-unit advance permission / bubble request
//   *_i                  execute-stage results and control
//   dhit, dmemload       dcache completion and load data
//   *_o, dload_o         latched values and captured load data
//   dmemREN/WEN/addr/store  dcache request
//   mem_stall, halted    upstream hold, sticky halt
//   stall_cnt            MEM_WAIT cycle count (only with EXMEM_STALLCNT_EN)
module exmem
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     enable,
    input  logic     flush,
    input  word_t    npc_i,
    input  word_t    aluout_i,
    input  word_t    rdat2_i,
    input  regbits_t wsel_i,
    input  logic     RegW_i,
    input  logic     DRen_i,
    input  logic     DWen_i,
    input  logic     jump_i,
    input  logic     halt_i,
    input  logic     dhit,
    input  word_t    dmemload,
    output word_t    npc_o,
    output word_t    aluout_o,
    output word_t    rdat2_o,
    output regbits_t wsel_o,
    output logic     RegW_o,
    output logic     DRen_o,
    output logic     DWen_o,
    output logic     jump_o,
    output logic     halt_o,
    output word_t    dload_o,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    output logic     mem_stall,
`ifdef EXMEM_STALLCNT_EN
    output logic [STALLCNT_W-1:0] stall_cnt,
`endif
    output logic     halted
);

    exmem_state_t state, state_n;
    exmem_latch_t lat, lat_n, lat_in;
    logic         pend_flush, pend_flush_n;
    word_t        dload_n;
    logic         halt_hold;

    assign lat_in = '{npc: npc_i, aluout: aluout_i, rdat2: rdat2_i,
                      wsel: wsel_i, regw: RegW_i, dren: DRen_i,
                      dwen: DWen_i, jump: jump_i, halt: halt_i};

    // State, latch and registered request/status outputs.
    // Request strobes and status are registered from the next state so they
    // line up exactly with the cycles the sequencer spends in each state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            lat        <= '0;
            pend_flush <= 1'b0;
            dload_o    <= '0;
            dmemREN    <= 1'b0;
            dmemWEN    <= 1'b0;
            mem_stall  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_n;
            lat        <= lat_n;
            pend_flush <= pend_flush_n;
            dload_o    <= dload_n;
            dmemREN    <= (state_n == MEM_WAIT) && lat_n.dren;
            dmemWEN    <= (state_n == MEM_WAIT) && lat_n.dwen;
            mem_stall  <= (state_n != IDLE);
            halted     <= (state_n == HALTED);
        end
    end

    // Next-state, latch advance and load capture.
    always_comb begin
        state_n      = state;
        lat_n        = lat;
        pend_flush_n = pend_flush;
        dload_n      = dload_o;
        halt_hold    = 1'b0;
        case (state)
            IDLE: begin
                // A latched halt with no memory op stops the pipe; the latch
                // must not advance past it, or the halt would be lost.
                halt_hold = lat.halt && !lat.dren && !lat.dwen;
                if (halt_hold) begin
                    state_n = HALTED;
                end else if (enable) begin
                    if (flush || pend_flush) begin
                        lat_n        = '0;
                        pend_flush_n = 1'b0;
                    end else begin
                        lat_n = lat_in;
                        if (DRen_i || DWen_i) begin
                            state_n = MEM_WAIT;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                // The access is never cancelled; a flush is remembered for
                // the next advance instead.
                if (flush) begin
                    pend_flush_n = 1'b1;
                end
                if (dhit) begin
                    if (lat.dren) begin
                        dload_n = dmemload;
                    end
                    state_n = IDLE;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef EXMEM_STALLCNT_EN
    // Saturating count of cycles spent waiting on the dcache.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (state == MEM_WAIT && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALLCNT_W'(1);
        end
    end
`endif

    assign npc_o     = lat.npc;
    assign aluout_o  = lat.aluout;
    assign rdat2_o   = lat.rdat2;
    assign wsel_o    = lat.wsel;
    assign RegW_o    = lat.regw;
    assign DRen_o    = lat.dren;
    assign DWen_o    = lat.dwen;
    assign jump_o    = lat.jump;
    assign halt_o    = lat.halt;
    assign dmemaddr  = lat.aluout;
    assign dmemstore = lat.rdat2;

endmodule

// File: tb/tb_exmem.sv
// Self-checking bench for exmem: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_exmem;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        enable = 1'b0, flush = 1'b0;
    logic [31:0] npc_i = '0, aluout_i = '0, rdat2_i = '0;
    logic [4:0]  wsel_i = '0;
    logic        RegW_i = 1'b0, DRen_i = 1'b0, DWen_i = 1'b0;
    logic        jump_i = 1'b0, halt_i = 1'b0;
    logic        dhit = 1'b0;
    logic [31:0] dmemload = '0;
    logic [31:0] npc_o, aluout_o, rdat2_o, dload_o, dmemaddr, dmemstore;
    logic [4:0]  wsel_o;
    logic        RegW_o, DRen_o, DWen_o, jump_o, halt_o;
    logic        dmemREN, dmemWEN, mem_stall, halted;
`ifdef EXMEM_STALLCNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    exmem dut (
        .CLK(CLK), .nRST(nRST), .enable(enable), .flush(flush),
        .npc_i(npc_i), .aluout_i(aluout_i), .rdat2_i(rdat2_i),
        .wsel_i(wsel_i), .RegW_i(RegW_i), .DRen_i(DRen_i), .DWen_i(DWen_i),
        .jump_i(jump_i), .halt_i(halt_i), .dhit(dhit), .dmemload(dmemload),
        .npc_o(npc_o), .aluout_o(aluout_o), .rdat2_o(rdat2_o),
        .wsel_o(wsel_o), .RegW_o(RegW_o), .DRen_o(DRen_o), .DWen_o(DWen_o),
        .jump_o(jump_o), .halt_o(halt_o), .dload_o(dload_o),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall),
`ifdef EXMEM_STALLCNT_EN
        .stall_cnt(stall_cnt),
`endif
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage is doing (free / waiting on dcache /
    // halted), the instruction it holds, and the remembered flush.
    localparam int M_FREE = 0, M_WAIT = 1, M_HALT = 2;
    int          m_mode = M_FREE;
    logic [31:0] m_npc = '0, m_alu = '0, m_rd2 = '0, m_dload = '0, m_cnt = '0;
    logic [4:0]  m_wsel = '0;
    logic        m_regw = 0, m_dren = 0, m_dwen = 0, m_jump = 0, m_halt = 0;
    logic        m_pend = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_mode <= M_FREE; m_pend <= 0; m_dload <= '0; m_cnt <= '0;
            {m_npc, m_alu, m_rd2, m_wsel, m_regw, m_dren, m_dwen, m_jump, m_halt} <= '0;
        end else begin
            if (m_mode == M_WAIT && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
            if (m_mode == M_FREE) begin
                if (m_halt && !m_dren && !m_dwen) begin
                    m_mode <= M_HALT;
                end else if (enable && (flush || m_pend)) begin
                    {m_npc, m_alu, m_rd2, m_wsel, m_regw, m_dren, m_dwen, m_jump, m_halt} <= '0;
                    m_pend <= 0;
                end else if (enable) begin
                    {m_npc, m_alu, m_rd2, m_wsel} <= {npc_i, aluout_i, rdat2_i, wsel_i};
                    {m_regw, m_dren, m_dwen, m_jump, m_halt} <= {RegW_i, DRen_i, DWen_i, jump_i, halt_i};
                    if (DRen_i || DWen_i) m_mode <= M_WAIT;
                end
            end else if (m_mode == M_WAIT) begin
                if (flush) m_pend <= 1;
                if (dhit) begin
                    if (m_dren) m_dload <= dmemload;
                    m_mode <= M_FREE;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            chk("npc_o", npc_o, m_npc);
            chk("aluout_o", aluout_o, m_alu);
            chk("rdat2_o", rdat2_o, m_rd2);
            chk("wsel_o", 32'(wsel_o), 32'(m_wsel));
            chk("ctrl_o", 32'({RegW_o, DRen_o, DWen_o, jump_o, halt_o}),
                32'({m_regw, m_dren, m_dwen, m_jump, m_halt}));
            chk("dload_o", dload_o, m_dload);
            chk("dmemREN", 32'(dmemREN), 32'(m_mode == M_WAIT && m_dren));
            chk("dmemWEN", 32'(dmemWEN), 32'(m_mode == M_WAIT && m_dwen));
            chk("dmemaddr", dmemaddr, m_alu);
            chk("dmemstore", dmemstore, m_rd2);
            chk("mem_stall", 32'(mem_stall), 32'(m_mode != M_FREE));
            chk("halted", 32'(halted), 32'(m_mode == M_HALT));
`ifdef EXMEM_STALLCNT_EN
            chk("stall_cnt", stall_cnt, m_cnt);
`endif
        end
    end

    task automatic quiet();
        enable = 0; flush = 0; DRen_i = 0; DWen_i = 0; RegW_i = 0;
        jump_i = 0; halt_i = 0; dhit = 0; npc_i = '0; aluout_i = '0;
        rdat2_i = '0; wsel_i = '0; dmemload = '0;
    endtask

    task automatic do_reset();
        nRST = 0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1;
    endtask

    // Issue one access from IDLE; dhit arrives on the last of 'waits' cycles.
    task automatic do_access(input logic is_load, input logic [31:0] a,
                             input logic [31:0] d, input int waits);
        quiet();
        aluout_i = a; enable = 1;
        if (is_load) DRen_i = 1; else begin DWen_i = 1; rdat2_i = d; end
        @(negedge CLK);
        quiet();
        for (int i = 0; i < waits; i++) begin
            chk("acc_strobe", 32'({dmemREN, dmemWEN}), is_load ? 32'd2 : 32'd1);
            chk("acc_addr", dmemaddr, a);
            chk("acc_stall", 32'(mem_stall), 32'd1);
            if (!is_load) chk("acc_store", dmemstore, d);
            if (i == waits - 1) begin dhit = 1; dmemload = is_load ? d : 32'hBAD0_BAD0; end
            @(negedge CLK);
            dhit = 0;
        end
        chk("acc_release", 32'(mem_stall), 32'd0);
    endtask

    initial begin
        int hc;
        int r;
        quiet();
        do_reset();
        @(negedge CLK);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_aluout", aluout_o, 32'd0);

        // Load with three wait cycles.
        do_access(1'b1, 32'h100, 32'hDEAD_BEEF, 3);
        chk("load_data", dload_o, 32'hDEAD_BEEF);

        // Store with one wait cycle; load data untouched.
        do_access(1'b0, 32'h200, 32'h1234_5678, 1);
        chk("store_keeps_dload", dload_o, 32'hDEAD_BEEF);

        // Flush during MEM_WAIT becomes a bubble on the next advance.
        quiet(); aluout_i = 32'h300; DRen_i = 1; enable = 1;
        @(negedge CLK);
        quiet(); flush = 1;
        @(negedge CLK);
        quiet();
        @(negedge CLK);
        dhit = 1; dmemload = 32'hCAFE_0001;
        @(negedge CLK);
        quiet(); npc_i = 32'h55; aluout_i = 32'h44; RegW_i = 1; wsel_i = 5'd7; enable = 1;
        chk("flush_done_data", dload_o, 32'hCAFE_0001);
        @(negedge CLK);
        quiet();
        chk("bubble_npc", npc_o, 32'd0);
        chk("bubble_alu", aluout_o, 32'd0);
        chk("bubble_regw", 32'({RegW_o, wsel_o}), 32'd0);
        @(negedge CLK);
        enable = 1; aluout_i = 32'h77;
        @(negedge CLK);
        quiet();
        chk("after_bubble_adv", aluout_o, 32'h77);

        // Async reset in the middle of an access.
        aluout_i = 32'h400; DRen_i = 1; enable = 1;
        @(negedge CLK);
        quiet();
        chk("mid_ren", 32'(dmemREN), 32'd1);
        nRST = 0;
        #1;
        chk("rst_mid_ren", 32'(dmemREN), 32'd0);
        chk("rst_mid_stall", 32'(mem_stall), 32'd0);
        chk("rst_mid_dren", 32'(DRen_o), 32'd0);
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);

        // Halt: sticky for 20 cycles regardless of inputs.
        halt_i = 1; enable = 1;
        @(negedge CLK);
        quiet();
        chk("halt_latched", 32'({halt_o, halted}), 32'd2);
        @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            chk("halted", 32'(halted), 32'd1);
            chk("halt_noreq", 32'({dmemREN, dmemWEN}), 32'd0);
            enable = 1'($urandom); flush = 1'($urandom); DRen_i = 1'($urandom);
            DWen_i = 1'($urandom); dhit = 1'($urandom); aluout_i = $urandom;
            @(negedge CLK);
        end
        quiet();

`ifdef EXMEM_STALLCNT_EN
        do_reset();
        @(negedge CLK);
        do_access(1'b1, 32'h10, 32'h1, 3);
        do_access(1'b1, 32'h14, 32'h2, 3);
        chk("stall_cnt_two_loads", stall_cnt, 32'd6);
`endif

        // Randomized run against the model.
        do_reset();
        hc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (hc > 20 || $urandom_range(0, 499) == 0) begin
                do_reset();
                hc = 0;
            end
            r = int'($urandom_range(0, 3));
            enable   = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            DRen_i   = (r == 1);
            DWen_i   = (r == 2);
            halt_i   = ($urandom_range(0, 59) == 0);
            RegW_i   = 1'($urandom);
            jump_i   = 1'($urandom);
            npc_i    = $urandom;
            aluout_i = $urandom;
            rdat2_i  = $urandom;
            wsel_i   = 5'($urandom);
            dhit     = ($urandom_range(0, 2) == 0);
            dmemload = $urandom;
            if (m_mode == M_HALT) hc++;
        end
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
